// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load and a one-entry valid/ready output buffer.
// Optional macro GRAY_COUNTER_BIN_OUT_EN adds a registered binary copy of each word on bin_out.
module gray_counter #(
    parameter int unsigned WIDTH = 4    // legal range 2..16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gray_out,
    output logic             out_valid,
    output logic             wrap,
    output logic             tc,
    output logic             busy
`ifdef GRAY_COUNTER_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin_out
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    logic             slot_free;
    logic             at_max, at_min;
    logic [WIDTH-1:0] step_count;
    logic             step_wraps;

    // Step arithmetic and terminal-count detection from the current binary count
    always_comb begin
        at_max     = (count_q == ALL_ONES);
        at_min     = (count_q == ALL_ZERO);
        step_count = up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        step_wraps = up_dn ? at_max : at_min;
    end

    assign slot_free = (state_q == EMPTY) || out_ready;

    // Buffer state register plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            count_q <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: load beats en; a stalled slot drops both requests
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gray_d  = gray_q;
        wrap_d  = wrap_q;
        if (slot_free) begin
            if (load) begin
                state_d = FULL;
                count_d = load_bin;
                gray_d  = to_gray(load_bin);
                wrap_d  = 1'b0;
            end else if (en) begin
                state_d = FULL;
                count_d = step_count;
                gray_d  = to_gray(step_count);
                wrap_d  = step_wraps;
            end else begin
                // Slot free with no request: either already empty or the word was just taken
                state_d = EMPTY;
            end
        end
    end

    assign gray_out  = gray_q;
    assign out_valid = (state_q == FULL);
    assign wrap      = wrap_q;
    assign tc        = step_wraps;
    assign busy      = (state_q == FULL) && !out_ready;

`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [WIDTH-1:0] bin_q;

    // Binary copy tracks the count, so it holds whenever the count holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
        end else begin
            bin_q <= count_d;
        end
    end

    assign bin_out = bin_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios followed by randomized traffic,
// all compared against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_gray_counter;

    localparam int unsigned W    = 4;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;
    logic         out_ready;
    logic [W-1:0] gray_out;
    logic         out_valid;
    logic         wrap;
    logic         tc;
    logic         busy;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [W-1:0] bin_out;
`endif

    gray_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_bin  (load_bin),
        .out_ready (out_ready),
        .gray_out  (gray_out),
        .out_valid (out_valid),
        .wrap      (wrap),
        .tc        (tc),
        .busy      (busy)
`ifdef GRAY_COUNTER_BIN_OUT_EN
        ,
        .bin_out   (bin_out)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: count as a plain integer modulo 2^W
    int unsigned m_count;
    int unsigned m_gray;
    bit          m_valid;
    bit          m_wrap;

    function automatic int unsigned gray_of(input int unsigned n);
        return (n ^ (n >> 1)) & MAXV;
    endfunction

    function automatic int unsigned bin_of(input int unsigned g);
        int unsigned b;
        b = 0;
        for (int s = 0; s < int'(W); s++) b = b ^ (g >> s);
        return b & MAXV;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_gray  = 0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_edge(input bit i_en, input bit i_up, input bit i_load,
                              input int unsigned i_lb, input bit i_rdy);
        if (!m_valid || i_rdy) begin
            if (i_load) begin
                m_count = i_lb & MAXV;
                m_gray  = gray_of(m_count);
                m_wrap  = 1'b0;
                m_valid = 1'b1;
            end else if (i_en) begin
                if (i_up) begin
                    m_wrap  = (m_count == MAXV);
                    m_count = (m_count + 1) % (MAXV + 1);
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + MAXV) % (MAXV + 1);
                end
                m_gray  = gray_of(m_count);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next
    task automatic drive_cycle(input bit i_en, input bit i_up, input bit i_load,
                               input int unsigned i_lb, input bit i_rdy);
        logic [W-1:0] prev_gray;
        bit           en_step;
        en        = i_en;
        up_dn     = i_up;
        load      = i_load;
        load_bin  = W'(i_lb);
        out_ready = i_rdy;
        #3;
        check_eq("tc", 32'(tc), 32'(i_up ? (m_count == MAXV) : (m_count == 0)));
        check_eq("busy", 32'(busy), 32'(m_valid && !i_rdy));
        prev_gray = gray_out;
        en_step   = (!m_valid || i_rdy) && !i_load && i_en;
        model_edge(i_en, i_up, i_load, i_lb, i_rdy);
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("gray_out", 32'(gray_out), 32'(m_gray));
            check_eq("wrap", 32'(wrap), 32'(m_wrap));
`ifdef GRAY_COUNTER_BIN_OUT_EN
            check_eq("bin_out", 32'(bin_out), 32'(bin_of(32'(gray_out))));
            check_eq("bin_out_model", 32'(bin_out), 32'(m_count));
`endif
        end
        if (en_step) check_eq("one_bit_step", 32'($countones(gray_out ^ prev_gray)), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        up_dn     = 1'b1;
        load      = 1'b0;
        load_bin  = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_eq("rst_gray", 32'(gray_out), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: nothing produced
        drive_cycle(0, 1, 0, 0, 1);

        // Full increment sweep, ending in the wrap word
        for (int i = 0; i < 16; i++) drive_cycle(1, 1, 0, 0, 1);
        check_eq("sweep_end_gray", 32'(gray_out), 32'd0);
        check_eq("sweep_end_wrap", 32'(wrap), 32'd1);

        // Load then decrement
        drive_cycle(0, 1, 1, 5, 1);
        check_eq("load5_gray", 32'(gray_out), 32'h7);
        drive_cycle(1, 0, 0, 0, 1);
        check_eq("dec_gray", 32'(gray_out), 32'h6);

        // Stall for three cycles, then resume with no skipped code
        drive_cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 1);
        // Load while stalled is dropped
        drive_cycle(0, 1, 0, 0, 0);
        drive_cycle(0, 1, 1, 9, 0);
        drive_cycle(0, 1, 0, 0, 1);

        // Decrement from zero wraps to all-ones
        drive_cycle(0, 0, 1, 0, 1);
        drive_cycle(1, 0, 0, 0, 1);
        check_eq("dec_wrap_gray", 32'(gray_out), 32'h8);
        check_eq("dec_wrap_flag", 32'(wrap), 32'd1);

        // Asynchronous reset mid-cycle while stalled
        drive_cycle(1, 1, 0, 0, 0);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_gray", 32'(gray_out), 32'd0);
        check_eq("async_rst_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(0, 1, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0);
        check_eq("first_after_rst", 32'(gray_out), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive_cycle(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 8) == 0,
                        $urandom % (MAXV + 1), ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL have one clock, `clk`; reset `rst_n` SHALL be asynchronous and active-low.
REQ-002 Parameter: WIDTH, default 4, counter and code width in bits (legal range 2..16).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: en  input  1  request to advance the count by one step.
REQ-006 Port: up_dn  input  1  direction select: 1 = increment, 0 = decrement.
REQ-007 Port: load  input  1  request to load a new start value.
REQ-008 Port: load_bin  input  WIDTH  binary value to load.
REQ-009 Port: out_ready  input  1  downstream gray-to-binary stage accepts the output word.
REQ-010 Port: gray_out  output  WIDTH  registered Gray-coded count word.
REQ-011 Port: out_valid  output  1  gray_out holds a word not yet accepted.
REQ-012 Port: wrap  output  1  registered flag, qualified by out_valid, marking the word produced by wrap-around.
REQ-013 Port: tc  output  1  combinational terminal-count flag.
REQ-014 Port: busy  output  1  combinational, equal to out_valid AND NOT out_ready.

Function
REQ-015 Internal state SHALL be a WIDTH-bit binary count plus a one-entry output buffer with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot-free SHALL be defined as (out_valid=0) OR (out_ready=1).
REQ-017 On a slot-free cycle with load=1, the module SHALL set count to load_bin, gray_out to load_bin ^ (load_bin >> 1), out_valid to 1 and wrap to 0 at the next edge; en and up_dn SHALL be ignored.
REQ-018 On a slot-free cycle with load=0 and en=1, the module SHALL set count to count±1 (modulo 2^WIDTH, per up_dn) and gray_out to the Gray code of the new count, and SHALL set out_valid to 1 at the next edge.
REQ-019 On a slot-free cycle with load=0 and en=0, the module SHALL set out_valid to 0 if out_ready=1 and SHALL hold count.
REQ-020 While busy=1, the module SHALL hold count, gray_out, wrap and out_valid unchanged, and load and en SHALL be ignored (dropped, not queued).
REQ-021 Output latency SHALL be one cycle from the accepting edge to the new word on gray_out.
REQ-022 wrap SHALL be 1 only on the word produced by an increment from all-ones to 0 or a decrement from 0 to all-ones.
REQ-023 tc SHALL be 1 when (up_dn=1 and count equals all-ones) or (up_dn=0 and count equals 0).
REQ-024 Consecutive words produced by en steps SHALL differ in exactly one bit of gray_out.
REQ-025 Accepting a word (out_valid=1 and out_ready=1) in the same cycle as a new step SHALL yield back-to-back valid words with no bubble.

Reset
REQ-026 While rst_n=0, the module SHALL force count=0, gray_out=0, out_valid=0 and wrap=0 immediately, regardless of clk.
REQ-027 A reset asserted while busy=1 SHALL discard the pending word.
REQ-028 The first step after reset deassertion SHALL be taken on the first slot-free edge with en or load high.

Configuration
REQ-029 Macro GRAY_COUNTER_BIN_OUT_EN: when defined, the module SHALL add output port `bin_out` (WIDTH bits), registered alongside gray_out, holding the binary count of the word (reset value 0, held under stall); when undefined, the port and its register SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-030 Reset then en=1, up_dn=1, out_ready=1 for 16 cycles (WIDTH=4) -> gray_out sequence 0001,0011,0010,0110,...,1000,0000; wrap=1 only on the final 0000 word.
REQ-031 load=1, load_bin=0101 -> gray_out=0111 one cycle later; then en=1, up_dn=0 -> next word 0110 (binary 0100).
REQ-032 While stepping, drop out_ready for 3 cycles -> busy=1, and gray_out and out_valid hold for those cycles; the count does not advance; the sequence resumes with no skipped code.
REQ-033 Count=0, up_dn=0: tc=1; one en step -> gray_out=1000, wrap=1.
REQ-034 Assert rst_n=0 mid-cycle while busy=1 -> out_valid, gray_out and wrap go to 0 without a clock edge.
REQ-035 With GRAY_COUNTER_BIN_OUT_EN defined, rerun REQ-030 -> bin_out equals the Gray-to-binary conversion of gray_out on every valid word.
